axis_tx_scheduler: RTL and testbench

Transmit-side scheduler for the SERDES link: arbitrates round-robin between `NUM_CH` upstream AXI-Stream word sources and sequences each granted word into a framed byte stream for the 8b/10b encoder. Each frame is a start-of-frame K-character, a channel-ID byte, and the word's bytes. The block emits K28.5 idle commas when no source is valid and forces a comma at least every `COMMA_PERIOD` bytes so the receiver can hold alignment. It sits between the per-channel AXIS producers and the encoder, replacing direct word-to-byte strobing.

---
 rtl/serdes_pkg.sv | 18 +
 rtl/axis_tx_scheduler_if.sv | 14 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/axis_tx_scheduler.sv | 116 +++++++++++
 tb/tb_axis_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// Shared SERDES transmit definitions: K-character codes, symbol byte type
// and the frame sequencer state encoding.
package serdes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t K28_5 = 8'hBC;
  localparam byte_t K27_7 = 8'hFB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_CHID,
    ST_DATA,
    ST_COMMA
  } state_t;

endpackage

// File: rtl/axis_tx_scheduler_if.sv
// Bundle of the per-channel AXI-Stream word sources feeding the scheduler.
interface axis_tx_scheduler_if #(
  parameter int NUM_CH     = 2,
  parameter int LOGIC_SIZE = 32
);

  logic [NUM_CH*LOGIC_SIZE-1:0] m_axis_tdata;
  logic [NUM_CH-1:0]            m_axis_valid;
  logic [NUM_CH-1:0]            m_axis_ready;

  modport master (output m_axis_tdata, output m_axis_valid, input m_axis_ready);
  modport slave  (input m_axis_tdata, input m_axis_valid, output m_axis_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      any
);

  localparam int W = $clog2(NUM_CH);

  logic [W-1:0] cand;
  logic         found;

  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NUM_CH) s = s - NUM_CH;
    return W'(s);
  endfunction

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = wrap_idx(ptr, i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_tx_scheduler.sv
// Round-robin AXIS word scheduler producing framed bytes (SOF, channel ID,
// data LSB first) for the 8b/10b encoder, with idle and forced K28.5 commas.
module axis_tx_scheduler
  import serdes_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int LOGIC_SIZE   = 32,
  parameter int COMMA_PERIOD = 256
) (
  input  logic                axis_aclk,
  input  logic                axis_reset_n,
  axis_tx_scheduler_if.slave  axis,
  input  logic                i_enc_ready,
  output byte_t               o_to_encoder,
  output logic                o_k_char,
  output logic                o_busy
);

  localparam int BYTES     = LOGIC_SIZE / 8;
  localparam int FRAME_LEN = BYTES + 2;
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W     = $clog2(COMMA_PERIOD + 1);
  localparam int DUE_AT    = (COMMA_PERIOD > FRAME_LEN) ? COMMA_PERIOD - FRAME_LEN : 0;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [LOGIC_SIZE-1:0]   word;
  logic [CH_W-1:0]         chan;
  logic [CH_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        count;

  logic [CH_W-1:0]         grant_idx;
  logic                    any_valid;
  logic                    last_byte;
  logic                    comma_due;
  logic                    capture;
  logic                    k28_sym;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (axis.m_axis_valid),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .any       (any_valid)
  );

  assign last_byte = (state == ST_DATA) && (idx == IDX_W'(BYTES - 1));
  assign comma_due = (count >= CNT_W'(DUE_AT));
  assign k28_sym   = (state == ST_IDLE) || (state == ST_COMMA);

  // Ready is gated by reset so a held-off source never sees a handshake
  // that the sequencer is about to discard.
  assign capture = axis_reset_n && i_enc_ready && !comma_due && any_valid &&
                   ((state == ST_IDLE) || last_byte);

  assign axis.m_axis_ready = capture ? (NUM_CH'(1) << grant_idx) : '0;
  assign o_busy            = (state != ST_IDLE);

  always_comb begin
    o_to_encoder = K28_5;
    o_k_char     = 1'b1;
    case (state)
      ST_SOF:  o_to_encoder = K27_7;
      ST_CHID: begin
        o_to_encoder = byte_t'(chan);
        o_k_char     = 1'b0;
      end
      ST_DATA: begin
        o_to_encoder = word[idx*8 +: 8];
        o_k_char     = 1'b0;
      end
      default: ;
    endcase
  end

  // Everything advances only when the encoder takes the current symbol.
  always_ff @(posedge axis_aclk) begin
    if (!axis_reset_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      word   <= '0;
      chan   <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else if (i_enc_ready) begin
      if (k28_sym)
        count <= '0;
      else if (count != CNT_W'(COMMA_PERIOD))
        count <= count + 1'b1;

      if (capture) begin
        word   <= axis.m_axis_tdata[grant_idx*LOGIC_SIZE +: LOGIC_SIZE];
        chan   <= grant_idx;
        rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end

      case (state)
        ST_IDLE:  if (capture) state <= ST_SOF;
        ST_SOF:   state <= ST_CHID;
        ST_CHID: begin
          state <= ST_DATA;
          idx   <= '0;
        end
        ST_DATA: begin
          if (!last_byte)    idx   <= idx + 1'b1;
          else if (comma_due) state <= ST_COMMA;
          else if (capture)   state <= ST_SOF;
          else                state <= ST_IDLE;
        end
        ST_COMMA: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_scheduler.sv
// Self-checking bench for axis_tx_scheduler: directed vector table, hand-written
// reset/alternation sequences, a queue-based symbol model under random traffic,
// and comma spacing on a short-period instance.
module tb_axis_tx_scheduler;
  import serdes_pkg::*;

  localparam int P_MAIN = 256;
  localparam int P_16   = 16;
  localparam int FLEN   = 6;

  logic  axis_aclk = 1'b0;
  logic  axis_reset_n;
  logic  enc_ready, enc16;
  byte_t sym, sym16;
  logic  k, k16, busy, busy16;

  always #5 axis_aclk = ~axis_aclk;

  axis_tx_scheduler_if #(.NUM_CH(2), .LOGIC_SIZE(32)) bus ();
  axis_tx_scheduler_if #(.NUM_CH(2), .LOGIC_SIZE(32)) bus16 ();

  axis_tx_scheduler #(.NUM_CH(2), .LOGIC_SIZE(32), .COMMA_PERIOD(P_MAIN)) dut (
    .axis_aclk    (axis_aclk),
    .axis_reset_n (axis_reset_n),
    .axis         (bus.slave),
    .i_enc_ready  (enc_ready),
    .o_to_encoder (sym),
    .o_k_char     (k),
    .o_busy       (busy)
  );

  axis_tx_scheduler #(.NUM_CH(2), .LOGIC_SIZE(32), .COMMA_PERIOD(P_16)) dut16 (
    .axis_aclk    (axis_aclk),
    .axis_reset_n (axis_reset_n),
    .axis         (bus16.slave),
    .i_enc_ready  (enc16),
    .o_to_encoder (sym16),
    .o_k_char     (k16),
    .o_busy       (busy16)
  );

  typedef struct {
    logic        en;
    logic [1:0]  v;
    logic [63:0] d;
    logic [7:0]  s;
    logic        kk;
    logic [1:0]  r;
    logic        b;
  } vec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       k;
    logic       dec;
    logic       idle;
  } sym_t;

  int checks = 0;
  int errors = 0;

  vec_t        tbl [26];
  sym_t        cur;
  sym_t        pend [$];
  int          mcnt, mrr, g, rdy_cnt, gap, max_gap, pairs, sofs;
  logic        due, capt, en;
  logic [1:0]  v, exp_r;
  logic [63:0] d;
  logic [31:0] w;
  logic [8:0]  cs, h1, h2, h3;

  localparam logic [63:0] W0    = 64'h0000_0000_DDCC_BBAA;
  localparam logic [63:0] W1    = 64'h0000_0000_4433_2211;
  localparam logic [63:0] W2    = 64'h0000_0000_8877_6655;
  localparam logic [63:0] D_ALT = {32'h2222_2222, 32'h1111_1111};

  function automatic vec_t mkv(logic e, logic [1:0] vv, logic [63:0] dd,
                               logic [7:0] s, logic kk, logic [1:0] r, logic b);
    vec_t x;
    x.en = e; x.v = vv; x.d = dd; x.s = s; x.kk = kk; x.r = r; x.b = b;
    return x;
  endfunction

  function automatic sym_t mk(logic [7:0] b, logic kk, logic dec, logic idle);
    sym_t x;
    x.b = b; x.k = kk; x.dec = dec; x.idle = idle;
    return x;
  endfunction

  function automatic logic [11:0] ex(logic [7:0] b, logic kk, logic bz, logic [1:0] r);
    return {b, kk, bz, r};
  endfunction

  function automatic logic [11:0] obsMain();
    return {sym, k, busy, bus.m_axis_ready};
  endfunction

  function automatic int rrGrant(logic [1:0] vv, int ptr);
    for (int i = 0; i < 2; i++)
      if (vv[(ptr + i) % 2]) return (ptr + i) % 2;
    return -1;
  endfunction

  task automatic applyStimulus(input logic e, input logic [1:0] vv,
                               input logic [63:0] dd, input logic rn);
    @(negedge axis_aclk);
    enc_ready        = e;
    bus.m_axis_valid = vv;
    bus.m_axis_tdata = dd;
    axis_reset_n     = rn;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic stepCheck(input string name, input logic e, input logic [1:0] vv,
                           input logic [63:0] dd, input logic rn, input logic [11:0] expv);
    applyStimulus(e, vv, dd, rn);
    checkOutput(name, obsMain(), expv);
  endtask

  task automatic modelReset();
    cur = mk(K28_5, 1'b1, 1'b1, 1'b1);
    pend.delete();
    mcnt = 0;
    mrr  = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0]  = mkv(1, 2'b01, W0, 8'hBC, 1, 2'b01, 0);
    tbl[1]  = mkv(1, 2'b00, W0, 8'hFB, 1, 2'b00, 1);
    tbl[2]  = mkv(1, 2'b00, W0, 8'h00, 0, 2'b00, 1);
    tbl[3]  = mkv(1, 2'b00, W0, 8'hAA, 0, 2'b00, 1);
    tbl[4]  = mkv(1, 2'b00, W0, 8'hBB, 0, 2'b00, 1);
    tbl[5]  = mkv(1, 2'b00, W0, 8'hCC, 0, 2'b00, 1);
    tbl[6]  = mkv(1, 2'b00, W0, 8'hDD, 0, 2'b00, 1);
    tbl[7]  = mkv(1, 2'b00, W0, 8'hBC, 1, 2'b00, 0);
    tbl[8]  = mkv(1, 2'b01, W1, 8'hBC, 1, 2'b01, 0);
    tbl[9]  = mkv(1, 2'b00, W1, 8'hFB, 1, 2'b00, 1);
    tbl[10] = mkv(1, 2'b00, W1, 8'h00, 0, 2'b00, 1);
    tbl[11] = mkv(1, 2'b00, W1, 8'h11, 0, 2'b00, 1);
    tbl[12] = mkv(0, 2'b00, W1, 8'h22, 0, 2'b00, 1);
    tbl[13] = mkv(0, 2'b00, W1, 8'h22, 0, 2'b00, 1);
    tbl[14] = mkv(1, 2'b00, W1, 8'h22, 0, 2'b00, 1);
    tbl[15] = mkv(1, 2'b00, W1, 8'h33, 0, 2'b00, 1);
    tbl[16] = mkv(0, 2'b01, W2, 8'h44, 0, 2'b00, 1);
    tbl[17] = mkv(0, 2'b01, W2, 8'h44, 0, 2'b00, 1);
    tbl[18] = mkv(1, 2'b01, W2, 8'h44, 0, 2'b01, 1);
    tbl[19] = mkv(1, 2'b00, W2, 8'hFB, 1, 2'b00, 1);
    tbl[20] = mkv(1, 2'b00, W2, 8'h00, 0, 2'b00, 1);
    tbl[21] = mkv(1, 2'b00, W2, 8'h55, 0, 2'b00, 1);
    tbl[22] = mkv(1, 2'b00, W2, 8'h66, 0, 2'b00, 1);
    tbl[23] = mkv(1, 2'b00, W2, 8'h77, 0, 2'b00, 1);
    tbl[24] = mkv(1, 2'b00, W2, 8'h88, 0, 2'b00, 1);
    tbl[25] = mkv(1, 2'b00, W2, 8'hBC, 1, 2'b00, 0);

    axis_reset_n       = 1'b0;
    enc_ready          = 1'b1;
    enc16              = 1'b1;
    bus.m_axis_valid   = '0;
    bus.m_axis_tdata   = '0;
    bus16.m_axis_valid = '0;
    bus16.m_axis_tdata = {32'h0807_0605, 32'h0403_0201};
    @(posedge axis_aclk);
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    #1;
    checkOutput("reset_main", obsMain(), ex(K28_5, 1, 0, 2'b00));
    checkOutput("reset_c16", {sym16, k16, busy16, bus16.m_axis_ready}, ex(K28_5, 1, 0, 2'b00));

    for (int n = 0; n < 300; n++)
      stepCheck("idle", 1'b1, 2'b00, 64'd0, 1'b1, ex(K28_5, 1, 0, 2'b00));

    for (int i = 0; i < 26; i++)
      stepCheck($sformatf("vec%0d", i), tbl[i].en, tbl[i].v, tbl[i].d, 1'b1,
                ex(tbl[i].s, tbl[i].kk, tbl[i].b, tbl[i].r));

    // Two saturated sources must interleave with no gap and one ready per frame.
    applyStimulus(1'b1, 2'b00, D_ALT, 1'b0);
    rdy_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      int p, f, o;
      logic [7:0] eb;
      logic       ek;
      logic [1:0] er;
      applyStimulus(1'b1, 2'b11, D_ALT, 1'b1);
      p  = c - 1;
      f  = p / 6;
      o  = p % 6;
      er = (c % 6 == 0) ? (((c / 6) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      if (c == 0)      begin eb = K28_5; ek = 1'b1; end
      else if (o == 0) begin eb = K27_7; ek = 1'b1; end
      else if (o == 1) begin eb = 8'(f % 2); ek = 1'b0; end
      else             begin eb = (f % 2 == 1) ? 8'h22 : 8'h11; ek = 1'b0; end
      if (c < 24 && bus.m_axis_ready != 2'b00) rdy_cnt++;
      checkOutput($sformatf("alt%0d", c), obsMain(), ex(eb, ek, (c != 0), er));
    end
    checkOutput("alt_ready_count", 64'(rdy_cnt), 64'd4);

    stepCheck("rst_sof",       1, 2'b00, D_ALT, 1, ex(K27_7, 1, 1, 2'b00));
    stepCheck("rst_chid",      1, 2'b00, D_ALT, 1, ex(8'h00, 0, 1, 2'b00));
    stepCheck("rst_d0",        1, 2'b00, D_ALT, 1, ex(8'h11, 0, 1, 2'b00));
    stepCheck("rst_d1",        1, 2'b00, D_ALT, 1, ex(8'h11, 0, 1, 2'b00));
    stepCheck("rst_d2_hold",   1, 2'b00, D_ALT, 0, ex(8'h11, 0, 1, 2'b00));
    stepCheck("rst_abort",     1, 2'b00, D_ALT, 1, ex(K28_5, 1, 0, 2'b00));
    stepCheck("rst_no_resend", 1, 2'b00, D_ALT, 1, ex(K28_5, 1, 0, 2'b00));
    stepCheck("rst_no_ready",  1, 2'b11, D_ALT, 0, ex(K28_5, 1, 0, 2'b00));
    stepCheck("rst_ptr_zero",  1, 2'b11, D_ALT, 1, ex(K28_5, 1, 0, 2'b01));
    stepCheck("rst_new_sof",   1, 2'b00, D_ALT, 1, ex(K27_7, 1, 1, 2'b00));
    stepCheck("rst_new_chid",  1, 2'b00, D_ALT, 1, ex(8'h00, 0, 1, 2'b00));
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 2'b00, D_ALT, 1'b1);

    // Random traffic against a symbol-queue model of the framing rules.
    applyStimulus(1'b1, 2'b00, 64'd0, 1'b0);
    modelReset();
    for (int n = 0; n < 1500; n++) begin
      v = {1'($urandom_range(9) != 0), 1'($urandom_range(9) != 0)};
      d = {$urandom, $urandom};
      en = 1'($urandom_range(4) != 0);
      applyStimulus(en, v, d, 1'b1);
      g     = rrGrant(v, mrr);
      due   = (mcnt >= P_MAIN - FLEN);
      capt  = en && cur.dec && !due && (g >= 0);
      exp_r = capt ? 2'(1 << g) : 2'b00;
      checkOutput("rand", obsMain(), ex(cur.b, cur.k, !cur.idle, exp_r));
      if (en) begin
        if (cur.k && cur.b == K28_5) mcnt = 0;
        else if (mcnt < P_MAIN)      mcnt = mcnt + 1;
        if (cur.dec && !cur.idle && due) begin
          cur = mk(K28_5, 1'b1, 1'b0, 1'b0);
          pend.push_back(mk(K28_5, 1'b1, 1'b1, 1'b1));
        end else if (capt) begin
          w   = (g == 1) ? d[63:32] : d[31:0];
          cur = mk(K27_7, 1'b1, 1'b0, 1'b0);
          pend.push_back(mk(8'(g), 1'b0, 1'b0, 1'b0));
          for (int b = 0; b < 4; b++)
            pend.push_back(mk(w[8*b +: 8], 1'b0, 1'(b == 3), 1'b0));
          mrr = (g + 1) % 2;
        end else if (cur.dec) begin
          cur = mk(K28_5, 1'b1, 1'b1, 1'b1);
        end else begin
          cur = pend.pop_front();
        end
      end
    end

    // Short comma period: measure spacing between consumed K28.5 symbols.
    applyStimulus(1'b1, 2'b00, 64'd0, 1'b0);
    gap = 0; max_gap = 0; pairs = 0; sofs = 0;
    h1 = '0; h2 = '0; h3 = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge axis_aclk);
      axis_reset_n       = 1'b1;
      enc16              = 1'b1;
      bus16.m_axis_valid = 2'b11;
      #1;
      cs = {k16, sym16};
      if (cs == {1'b1, K28_5}) begin
        if (gap > max_gap) max_gap = gap;
        gap = 0;
      end else begin
        gap++;
      end
      if (cs == {1'b1, K27_7}) begin
        sofs++;
        if (h1 == {1'b1, K28_5} && h2 == {1'b1, K28_5} && h3[8] == 1'b0) pairs++;
      end
      h3 = h2; h2 = h1; h1 = cs;
    end
    checkRange("c16_max_gap", max_gap, 1, P_16);
    checkRange("c16_comma_pairs", pairs, 10, 200);
    checkRange("c16_frames", sofs, 20, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
